sv_ex: RTL and testbench

Execute stage of the signature core. It sits directly downstream of the instruction sequencer and consumes the 15-bit execute instruction and its one-cycle valid strobe. It holds an 8-entry word register file and performs ALU, compare, block-load and multi-cycle rotate operations. It returns a one-cycle completion pulse and a sticky compare flag that the sequencer uses for conditional jumps.

---
 rtl/sv_ex.sv | 186 ++++++++++++++++++
 tb/tb_sv_ex.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sv_ex.sv
// Execute stage of the signature core: 8-entry register file, ALU/compare,
// block-word load and bit-serial rotate/shift, with a registered completion pulse.
module sv_ex #(
  parameter int BLOCK_SIZE = 512,
  parameter int WORD_W     = 64
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic [14:0]           ex_i_i,
  input  logic                  ex_v_i,
  output logic                  ex_c_o,
  output logic                  ex_r_o,
  input  logic [BLOCK_SIZE-1:0] block_i,
  output logic [WORD_W-1:0]     res_o,
  output logic                  busy_o
);

  localparam int N_WORDS = BLOCK_SIZE / WORD_W;
  localparam int SH_W    = $clog2(WORD_W);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_SHIFT, S_DONE} state_t;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,  OP_ADD   = 4'd1,  OP_SUB  = 4'd2,  OP_XOR = 4'd3,
    OP_AND   = 4'd4,  OP_OR    = 4'd5,  OP_MOV  = 4'd6,  OP_LDI = 4'd7,
    OP_LDB   = 4'd8,  OP_CMPEQ = 4'd9,  OP_CMPLT = 4'd10,
    OP_ROTR  = 4'd11, OP_SHR   = 4'd12
  } op_t;

  state_t state_q, state_d;

  logic [WORD_W-1:0] rf_q [8];
  logic [WORD_W-1:0] work_q;
  logic [SH_W-1:0]   count_q;
  logic [2:0]        rd_q;
  logic              wr_reg_q, wr_flag_q, cmp_q, rot_q;
  logic              ex_c_q, ex_r_q, busy_q;

  // Instruction fields; rs2/idx and rs1/imm8 deliberately overlap.
  op_t        op;
  logic [2:0] rd, rs1, rs2;
  logic [7:0] imm8;
  logic [5:0] idx;

  assign op   = op_t'(ex_i_i[3:0]);
  assign rd   = ex_i_i[6:4];
  assign rs1  = ex_i_i[9:7];
  assign rs2  = ex_i_i[12:10];
  assign imm8 = ex_i_i[14:7];
  assign idx  = ex_i_i[12:7];

  logic [WORD_W-1:0] rs1_val, rs2_val, blk_word;
  logic [SH_W-1:0]   sh_n;

  assign rs1_val = rf_q[rs1];
  assign rs2_val = rf_q[rs2];
  assign sh_n    = rs2_val[SH_W-1:0];

  always_comb begin
    blk_word = '0;
    for (int k = 0; k < N_WORDS; k++) begin
      if (int'(idx) == k) blk_word = block_i[k*WORD_W +: WORD_W];
    end
  end

  // Decode/compute at accept; the result is held in work_q until writeback.
  logic [WORD_W-1:0] alu_res;
  logic              wr_reg, wr_flag, cmp, is_shift;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    alu_res  = '0;
    wr_reg   = 1'b0;
    wr_flag  = 1'b0;
    cmp      = 1'b0;
    is_shift = 1'b0;
    case (op)
      OP_ADD:   begin alu_res = rs1_val + rs2_val; wr_reg = 1'b1; end
      OP_SUB:   begin alu_res = rs1_val - rs2_val; wr_reg = 1'b1; end
      OP_XOR:   begin alu_res = rs1_val ^ rs2_val; wr_reg = 1'b1; end
      OP_AND:   begin alu_res = rs1_val & rs2_val; wr_reg = 1'b1; end
      OP_OR:    begin alu_res = rs1_val | rs2_val; wr_reg = 1'b1; end
      OP_MOV:   begin alu_res = rs1_val;           wr_reg = 1'b1; end
      OP_LDI:   begin alu_res = WORD_W'(imm8);     wr_reg = 1'b1; end
      OP_LDB:   begin alu_res = blk_word;          wr_reg = 1'b1; end
      OP_CMPEQ: begin cmp = (rs1_val == rs2_val);  wr_flag = 1'b1; end
      OP_CMPLT: begin cmp = (rs1_val <  rs2_val);  wr_flag = 1'b1; end
      OP_ROTR, OP_SHR: begin
        alu_res  = rs1_val;
        wr_reg   = 1'b1;
        is_shift = 1'b1;
      end
      default: ;
    endcase
  end

  logic [WORD_W-1:0] shifted;
  assign shifted = rot_q ? {work_q[0], work_q[WORD_W-1:1]}
                         : {1'b0,      work_q[WORD_W-1:1]};

  logic              accept, wb_en, flag_en, busy_d, ex_r_d;
  logic [WORD_W-1:0] wb_data;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    wb_en   = 1'b0;
    wb_data = work_q;
    flag_en = 1'b0;
    busy_d  = busy_q;
    ex_r_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ex_v_i) begin
          accept  = 1'b1;
          busy_d  = 1'b1;
          state_d = (is_shift && sh_n != '0) ? S_SHIFT : S_EXEC;
        end
      end
      S_EXEC: begin
        wb_en   = wr_reg_q;
        flag_en = wr_flag_q;
        state_d = S_DONE;
      end
      S_SHIFT: begin
        if (count_q == SH_W'(1)) begin
          wb_en   = 1'b1;
          wb_data = shifted;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        ex_r_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // NOTE: the register file is reset explicitly; an abort must leave r0..r7 at zero.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
      work_q    <= '0;
      count_q   <= '0;
      rd_q      <= '0;
      wr_reg_q  <= 1'b0;
      wr_flag_q <= 1'b0;
      cmp_q     <= 1'b0;
      rot_q     <= 1'b0;
      ex_c_q    <= 1'b0;
      ex_r_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      if (accept) begin
        rd_q      <= rd;
        work_q    <= alu_res;
        cmp_q     <= cmp;
        wr_reg_q  <= wr_reg;
        wr_flag_q <= wr_flag;
        rot_q     <= (op == OP_ROTR);
        count_q   <= sh_n;
      end else if (state_q == S_SHIFT) begin
        work_q  <= shifted;
        count_q <= count_q - 1'b1;
      end
      if (wb_en)   rf_q[rd_q] <= wb_data;
      if (flag_en) ex_c_q     <= cmp_q;
      busy_q <= busy_d;
      ex_r_q <= ex_r_d;
    end
  end

  assign res_o  = rf_q[0];
  assign ex_c_o = ex_c_q;
  assign ex_r_o = ex_r_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_sv_ex.sv
// Directed bench for sv_ex: a vector table of single instructions plus
// hand-written rotate, busy-strobe and mid-operation reset sequences.
module tb_sv_ex;

  localparam int BLOCK_SIZE = 512;
  localparam int WORD_W     = 64;

  logic                  clk = 1'b0;
  logic                  areset;
  logic [14:0]           ex_i_i;
  logic                  ex_v_i;
  logic                  ex_c_o, ex_r_o, busy_o;
  logic [BLOCK_SIZE-1:0] block_i;
  logic [WORD_W-1:0]     res_o;

  int checks   = 0;
  int failures = 0;

  sv_ex #(.BLOCK_SIZE(BLOCK_SIZE), .WORD_W(WORD_W)) dut (
    .clk(clk), .areset(areset), .ex_i_i(ex_i_i), .ex_v_i(ex_v_i),
    .ex_c_o(ex_c_o), .ex_r_o(ex_r_o), .block_i(block_i),
    .res_o(res_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [14:0] enc_r(input int op, input int rd, input int rs1, input int rs2);
    return {2'b00, 3'(rs2), 3'(rs1), 3'(rd), 4'(op)};
  endfunction

  function automatic logic [14:0] enc_i(input int op, input int rd, input int imm);
    return {8'(imm), 3'(rd), 4'(op)};
  endfunction

  // Issue one instruction; report latency in edges after the accepting edge.
  task automatic issue(input logic [14:0] ins, output int lat);
    @(negedge clk);
    ex_i_i = ins;
    ex_v_i = 1'b1;
    @(posedge clk);
    #1 ex_v_i = 1'b0;
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
      if (ex_r_o) break;
    end
  endtask

  task automatic run_op(input string name, input logic [14:0] ins, input logic [63:0] exp_res,
                        input logic exp_c, input int exp_lat);
    int lat;
    issue(ins, lat);
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " res_o"}, res_o, exp_res);
    check({name, " ex_c_o"}, 64'(ex_c_o), 64'(exp_c));
    check({name, " busy_o at pulse"}, 64'(busy_o), 64'd0);
    @(posedge clk);
    #1 check({name, " pulse width"}, 64'(ex_r_o), 64'd0);
  endtask

  typedef struct {
    string       name;
    logic [14:0] ins;
    logic [63:0] res;
    logic        c;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int lat;
    bit saw_pulse;

    areset  = 1'b0;
    ex_v_i  = 1'b0;
    ex_i_i  = '0;
    block_i = '0;
    block_i[3*64 +: 64] = 64'hDEADBEEF_01234567;
    block_i[7*64 +: 64] = 64'h7777_0000_0000_0007;

    repeat (2) @(posedge clk);
    #1;
    check("reset res_o", res_o, 64'd0);
    check("reset ex_c_o", 64'(ex_c_o), 64'd0);
    check("reset ex_r_o", 64'(ex_r_o), 64'd0);
    check("reset busy_o", 64'(busy_o), 64'd0);
    @(negedge clk) areset = 1'b1;

    vecs.push_back('{"ldi r1",   enc_i(7, 1, 8'h25),  64'd0,  1'b0, 2});
    vecs.push_back('{"ldi r2",   enc_i(7, 2, 8'h13),  64'd0,  1'b0, 2});
    vecs.push_back('{"add",      enc_r(1, 0, 1, 2),   64'h38, 1'b0, 2});
    vecs.push_back('{"sub wrap", enc_r(2, 0, 2, 1),   64'hFFFF_FFFF_FFFF_FFEE, 1'b0, 2});
    vecs.push_back('{"ldb 3",    enc_i(8, 4, 3),      64'hFFFF_FFFF_FFFF_FFEE, 1'b0, 2});
    vecs.push_back('{"mov ldb3", enc_r(6, 0, 4, 0),   64'hDEADBEEF_01234567, 1'b0, 2});
    vecs.push_back('{"ldb 7",    enc_i(8, 4, 7),      64'hDEADBEEF_01234567, 1'b0, 2});
    vecs.push_back('{"mov ldb7", enc_r(6, 0, 4, 0),   64'h7777_0000_0000_0007, 1'b0, 2});
    vecs.push_back('{"ldb 9",    enc_i(8, 4, 9),      64'h7777_0000_0000_0007, 1'b0, 2});
    vecs.push_back('{"mov ldb9", enc_r(6, 0, 4, 0),   64'd0,  1'b0, 2});
    vecs.push_back('{"cmpeq",    enc_r(9, 0, 1, 1),   64'd0,  1'b1, 2});
    vecs.push_back('{"add keep", enc_r(1, 0, 1, 2),   64'h38, 1'b1, 2});
    vecs.push_back('{"cmplt f",  enc_r(10, 0, 0, 1),  64'h38, 1'b0, 2});
    vecs.push_back('{"cmplt t",  enc_r(10, 0, 1, 0),  64'h38, 1'b1, 2});
    vecs.push_back('{"xor",      enc_r(3, 0, 1, 2),   64'h36, 1'b1, 2});
    vecs.push_back('{"and",      enc_r(4, 0, 1, 2),   64'h01, 1'b1, 2});
    vecs.push_back('{"or",       enc_r(5, 0, 1, 2),   64'h37, 1'b1, 2});
    vecs.push_back('{"nop",      enc_r(0, 0, 1, 2),   64'h37, 1'b1, 2});
    vecs.push_back('{"op 13",    enc_r(13, 0, 1, 2),  64'h37, 1'b1, 2});
    vecs.push_back('{"rotr n=0", enc_r(11, 0, 1, 6),  64'h25, 1'b1, 2});
    vecs.push_back('{"ldi r5",   enc_i(7, 5, 8'h02),  64'h25, 1'b1, 2});
    vecs.push_back('{"shr n=2",  enc_r(12, 0, 1, 5),  64'h09, 1'b1, 3});
    vecs.push_back('{"rotr n=2", enc_r(11, 0, 1, 5),  64'h4000_0000_0000_0009, 1'b1, 3});

    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].ins, vecs[i].res, vecs[i].c, vecs[i].lat);

    // Multi-cycle rotate with a stray strobe mid-operation.
    run_op("ldi r1=1", enc_i(7, 1, 8'h01), 64'h4000_0000_0000_0009, 1'b1, 2);
    run_op("ldi r2=44", enc_i(7, 2, 8'h44), 64'h4000_0000_0000_0009, 1'b1, 2);
    @(negedge clk);
    ex_i_i = enc_r(11, 3, 1, 2);
    ex_v_i = 1'b1;
    @(posedge clk);
    #1 ex_v_i = 1'b0;
    lat = 0;
    saw_pulse = 1'b0;
    while (lat < 200 && !saw_pulse) begin
      check("rotr busy_o during op", 64'(busy_o), 64'd1);
      if (lat == 1) begin
        @(negedge clk);
        ex_i_i = enc_i(7, 3, 8'hFF);
        ex_v_i = 1'b1;
      end
      @(posedge clk);
      lat++;
      #1 ex_v_i = 1'b0;
      saw_pulse = ex_r_o;
    end
    check("rotr latency", 64'(lat), 64'd5);
    @(posedge clk);
    #1 check("rotr no extra pulse", 64'(ex_r_o), 64'd0);
    run_op("mov r0=r3", enc_r(6, 0, 3, 0), 64'h1000_0000_0000_0000, 1'b1, 2);

    // Reset in the middle of a long rotate.
    run_op("ldi r5=40", enc_i(7, 5, 8'd40), 64'h1000_0000_0000_0000, 1'b1, 2);
    @(negedge clk);
    ex_i_i = enc_r(11, 3, 1, 5);
    ex_v_i = 1'b1;
    @(posedge clk);
    #1 ex_v_i = 1'b0;
    repeat (10) @(posedge clk);
    #1 areset = 1'b0;
    #1;
    check("abort res_o", res_o, 64'd0);
    check("abort ex_c_o", 64'(ex_c_o), 64'd0);
    check("abort ex_r_o", 64'(ex_r_o), 64'd0);
    check("abort busy_o", 64'(busy_o), 64'd0);
    @(negedge clk) areset = 1'b1;
    run_op("post-abort mov r1", enc_r(6, 0, 1, 0), 64'd0, 1'b0, 2);
    run_op("post-abort mov r3", enc_r(6, 0, 3, 0), 64'd0, 1'b0, 2);
    run_op("post-abort ldi", enc_i(7, 0, 8'h5A), 64'h5A, 1'b0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
